// File: rtl/bbf_accumulator_if.sv
// Stream bundle for bbf_accumulator: sample input channel and sum output channel.
// master drives samples and consumes sums; slave is the accumulator.
interface bbf_accumulator_if;
  logic [63:0] in_bits;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_bits;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_bits, in_valid, out_ready,
    input  in_ready, out_bits, out_valid
  );

  modport slave (
    input  in_bits, in_valid, out_ready,
    output in_ready, out_bits, out_valid
  );
endinterface

// File: rtl/bbf_accumulator.sv
// Streaming IEEE-754 double accumulator (simulation model): sums LENGTH accepted samples
// and presents the sum LATENCY+1 cycles after the last accept, held until consumed.
module bbf_accumulator #(
  parameter int unsigned LENGTH  = 8,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = $clog2(LENGTH + 1)
) (
  input logic              clock,
  input logic              reset,
  bbf_accumulator_if.slave bus
);

  localparam int unsigned FlW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  typedef enum logic [1:0] {StAccum, StFlush, StOut} state_e;

  state_e           state_q, state_d;
  logic [63:0]      acc_q, acc_d;
  logic [63:0]      out_bits_q, out_bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FlW-1:0]   flush_q, flush_d;
  logic             accept;
  logic             last;

  assign bus.in_ready  = (state_q == StAccum) && !reset;
  assign bus.out_valid = (state_q == StOut) && !reset;
  assign bus.out_bits  = out_bits_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (cnt_q == CNT_W'(LENGTH - 1));

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    flush_d    = flush_q;
    out_bits_d = out_bits_q;
    unique case (state_q)
      StAccum: begin
        if (accept) begin
          acc_d = $realtobits($bitstoreal(acc_q) + $bitstoreal(bus.in_bits));
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            if (LATENCY == 0) begin
              state_d = StOut;
            end else begin
              state_d = StFlush;
              flush_d = FlW'(LATENCY);
            end
          end
        end
      end
      StFlush: begin
        if (flush_q == FlW'(1)) state_d = StOut;
        else                    flush_d = flush_q - FlW'(1);
      end
      StOut: begin
        if (bus.out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
    // Capture the sum only on entry to StOut so it stays stable while stalled.
    if (state_d == StOut && state_q != StOut) out_bits_d = acc_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      cnt_q      <= '0;
      flush_q    <= '0;
      out_bits_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      out_bits_q <= out_bits_d;
    end
  end

endmodule
